// File: rtl/mandel_view_ctrl.sv
// mandel_view_ctrl: turns debounced button levels into Mandelbrot view updates and render-start pulses
//   Clk                 rising-edge system clock
//   Reset               synchronous active-high reset
//   BtnUp/Down/Left/Right/ZoomIn/ZoomOut  debounced button levels, active high
//   RenderBusy          high while the renderer is drawing a frame
//   CenterX, CenterY    signed Q4.28 view centre (real, imaginary)
//   ZoomLevel           current zoom level, 0..MAX_ZOOM
//   StartRender         one-cycle pulse requesting a new frame
// Optional build macro AUTO_REPEAT_EN adds auto-repeat for held pan buttons.
module mandel_view_ctrl #(
    parameter int                 COORD_W     = 32,
    parameter int                 ZOOM_W      = 5,
    parameter int                 MAX_ZOOM    = 24,
    parameter logic [COORD_W-1:0] STEP_BASE   = 32'h0200_0000,
    parameter logic [COORD_W-1:0] COORD_LIMIT = 32'h2000_0000,
    parameter logic [COORD_W-1:0] INIT_X      = 32'hF800_0000,
    parameter logic [COORD_W-1:0] INIT_Y      = 32'h0000_0000
`ifdef AUTO_REPEAT_EN
    ,
    parameter int                 HOLD_CYCLES   = 25000000,
    parameter int                 REPEAT_CYCLES = 5000000
`endif
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               BtnUp,
    input  logic               BtnDown,
    input  logic               BtnLeft,
    input  logic               BtnRight,
    input  logic               BtnZoomIn,
    input  logic               BtnZoomOut,
    input  logic               RenderBusy,
    output logic [COORD_W-1:0] CenterX,
    output logic [COORD_W-1:0] CenterY,
    output logic [ZOOM_W-1:0]  ZoomLevel,
    output logic               StartRender
);
    typedef enum logic [1:0] {IDLE, UPDATE, START, WAIT} state_t;

    localparam logic signed [COORD_W:0] LIM  = {1'b0, COORD_LIMIT};
    localparam logic [ZOOM_W-1:0]       ZMAX = ZOOM_W'(MAX_ZOOM);

    state_t state, state_nx;
    // Bit order doubles as priority: bit 0 (ZoomIn) is highest.
    logic [5:0] btn, hist, syn, edges, pend, req, win, act;
    logic [COORD_W-1:0] step, cur;
    logic signed [COORD_W:0] sum, sat;

    assign btn   = {BtnRight, BtnLeft, BtnDown, BtnUp, BtnZoomOut, BtnZoomIn};
    assign edges = (btn & ~hist) | syn;
    assign req   = edges | pend;
    // Isolate the lowest set bit, i.e. the highest-priority request.
    assign win   = req & (~req + 6'd1);

`ifdef AUTO_REPEAT_EN
    localparam int CW = $clog2((HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES) + 1);

    logic [3:0]    held, sel, sel_q;
    logic [CW-1:0] cnt;
    logic          rep, fire;

    // One shared counter follows the highest-priority held pan button.
    assign held = btn[5:2];
    assign sel  = held & (~held + 4'd1);
    assign fire = (|sel) && (sel == sel_q) &&
                  (cnt == CW'(rep ? REPEAT_CYCLES - 1 : HOLD_CYCLES - 1));
    assign syn  = fire ? {sel, 2'b00} : 6'd0;

    always_ff @(posedge Clk) begin
        if (Reset || !(|sel) || sel != sel_q) begin
            cnt   <= '0;
            rep   <= 1'b0;
            sel_q <= Reset ? 4'd0 : sel;
        end else if (fire) begin
            cnt <= '0;
            rep <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign syn = 6'd0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |req ? UPDATE : IDLE;
            UPDATE:  state_nx = START;
            START:   state_nx = WAIT;
            default: state_nx = RenderBusy ? WAIT : IDLE;
        endcase
    end

    // Pan arithmetic is one bit wider than the coordinate so the clamp sees true overflow.
    always_comb begin
        step = STEP_BASE >> ZoomLevel;
        cur  = (act[2] | act[3]) ? CenterY : CenterX;
        sum  = (act[3] | act[4]) ? {cur[COORD_W-1], cur} - {1'b0, step}
                                 : {cur[COORD_W-1], cur} + {1'b0, step};
        sat  = sum > LIM ? LIM : (sum < -LIM ? -LIM : sum);
    end

    // Reset parks the FSM in START so the first frame is requested right after release.
    assign StartRender = (state == START) && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= START;
            hist      <= '0;
            pend      <= '0;
            act       <= '0;
            CenterX   <= INIT_X;
            CenterY   <= INIT_Y;
            ZoomLevel <= '0;
        end else begin
            state <= state_nx;
            hist  <= btn;
            pend  <= state == IDLE ? 6'd0 : pend | edges;
            if (state == IDLE)
                act <= win;
            if (state == UPDATE) begin
                if (act[0])
                    ZoomLevel <= ZoomLevel == ZMAX ? ZoomLevel : ZoomLevel + 1'b1;
                if (act[1])
                    ZoomLevel <= ZoomLevel == '0 ? ZoomLevel : ZoomLevel - 1'b1;
                if (act[2] | act[3])
                    CenterY <= sat[COORD_W-1:0];
                if (act[4] | act[5])
                    CenterX <= sat[COORD_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_mandel_view_ctrl.sv
// tb_mandel_view_ctrl: scoreboard bench for mandel_view_ctrl
module tb_mandel_view_ctrl;
    typedef struct {
        longint x;
        longint y;
        int     z;
    } view_t;

    localparam longint LIM    = 64'sh2000_0000;
    localparam longint INIT_X = -64'sh0800_0000;
    localparam logic [5:0] ZI = 6'b000001, ZO = 6'b000010, UP = 6'b000100,
                           DN = 6'b001000, LF = 6'b010000, RT = 6'b100000;

    logic        Clk = 1'b0, Reset = 1'b1, RenderBusy = 1'b0;
    logic [5:0]  btn = 6'd0;
    logic [31:0] CenterX, CenterY;
    logic [4:0]  ZoomLevel;
    logic        StartRender;

    view_t  sb[$];
    view_t  e;
    longint mx = INIT_X, my = 0;
    int     mz = 0;
    int     tests = 0, fails = 0, pulses = 0;
    logic   prev_sr = 1'b0;

    always #5 Clk = ~Clk;

    mandel_view_ctrl dut (
        .Clk(Clk), .Reset(Reset),
        .BtnUp(btn[2]), .BtnDown(btn[3]), .BtnLeft(btn[4]), .BtnRight(btn[5]),
        .BtnZoomIn(btn[0]), .BtnZoomOut(btn[1]),
        .RenderBusy(RenderBusy),
        .CenterX(CenterX), .CenterY(CenterY), .ZoomLevel(ZoomLevel),
        .StartRender(StartRender)
    );

    // Every StartRender pulse pops one expected view and must last one cycle.
    always @(negedge Clk) begin
        if (StartRender === 1'b1) begin
            pulses++;
            tests++;
            if (prev_sr) begin
                fails++;
                $display("FAIL pulse_width: StartRender high on consecutive cycles");
            end
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: x=%h y=%h z=%0d, no view expected", CenterX, CenterY, ZoomLevel);
            end else begin
                e = sb.pop_front();
                if (longint'($signed(CenterX)) !== e.x || longint'($signed(CenterY)) !== e.y || int'(ZoomLevel) !== e.z) begin
                    fails++;
                    $display("FAIL view: got x=%h y=%h z=%0d, expected x=%h y=%h z=%0d",
                             CenterX, CenterY, ZoomLevel, 32'(e.x), 32'(e.y), e.z);
                end
            end
        end
        prev_sr = (StartRender === 1'b1);
    end

    function automatic longint clamp(input longint v);
        return v > LIM ? LIM : (v < -LIM ? -LIM : v);
    endfunction

    task automatic model(input logic [5:0] m);
        longint st = 64'h0200_0000 >> mz;
        if (m[0]) mz = mz == 24 ? 24 : mz + 1;
        else if (m[1]) mz = mz == 0 ? 0 : mz - 1;
        else if (m[2]) my = clamp(my + st);
        else if (m[3]) my = clamp(my - st);
        else if (m[4]) mx = clamp(mx - st);
        else if (m[5]) mx = clamp(mx + st);
        sb.push_back('{mx, my, mz});
    endtask

    task automatic drive(input logic [5:0] m);
        @(negedge Clk) btn = m;
        @(negedge Clk) btn = 6'd0;
    endtask

    task automatic wait_pulses(input int n, input string name);
        for (int i = 0; i < 60 && pulses < n; i++) @(negedge Clk);
        tests++;
        if (pulses < n) begin
            fails++;
            $display("FAIL %s_timeout: pulses=%0d, expected %0d", name, pulses, n);
        end
    endtask

    task automatic do_press(input logic [5:0] m);
        int n = pulses + 1;
        model(m);
        drive(m);
        wait_pulses(n, "press");
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        tests++;
        if (CenterX !== 32'hF800_0000 || CenterY !== 32'h0 || ZoomLevel !== 5'd0 || StartRender !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: x=%h y=%h z=%0d sr=%b, expected f8000000 0 0 0", CenterX, CenterY, ZoomLevel, StartRender);
        end
        sb.push_back('{mx, my, mz});
        @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        tests++;
        if (StartRender !== 1'b1) begin
            fails++;
            $display("FAIL first_frame: StartRender=%b, expected 1", StartRender);
        end
        wait_pulses(1, "reset");
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_right_latency;
        model(RT);
        @(negedge Clk) btn = RT;
        @(negedge Clk) btn = 6'd0;
        tests++;
        if (StartRender !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: StartRender=%b one cycle after edge, expected 0", StartRender);
        end
        @(negedge Clk);
        tests++;
        if (StartRender !== 1'b1 || CenterX !== 32'hFA00_0000) begin
            fails++;
            $display("FAIL latency_n2: sr=%b x=%h, expected 1 fa000000", StartRender, CenterX);
        end
        @(negedge Clk);
        tests++;
        if (StartRender !== 1'b0) begin
            fails++;
            $display("FAIL latency_late: StartRender=%b, expected 0", StartRender);
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_simultaneous;
        int p0 = pulses;
        do_press(ZI | UP);
        repeat (5) @(negedge Clk);
        tests++;
        if (pulses - p0 !== 1 || ZoomLevel !== 5'd1 || CenterY !== 32'h0) begin
            fails++;
            $display("FAIL simultaneous: pulses=%0d z=%0d y=%h, expected 1 1 0", pulses - p0, ZoomLevel, CenterY);
        end
    endtask

    task automatic test_zoom_limits;
        longint y0;
        int p0;
        do_press(ZI);
        do_press(ZI);
        tests++;
        if (ZoomLevel !== 5'd3) begin
            fails++;
            $display("FAIL zoom3: z=%0d, expected 3", ZoomLevel);
        end
        y0 = longint'($signed(CenterY));
        do_press(UP);
        tests++;
        if (longint'($signed(CenterY)) - y0 !== 64'h40_0000) begin
            fails++;
            $display("FAIL step_zoom3: delta=%h, expected 400000", longint'($signed(CenterY)) - y0);
        end
        for (int i = 0; i < 30; i++) do_press(ZI);
        tests++;
        if (ZoomLevel !== 5'd24) begin
            fails++;
            $display("FAIL zoom_max: z=%0d, expected 24", ZoomLevel);
        end
        for (int i = 0; i < 24; i++) do_press(ZO);
        p0 = pulses;
        do_press(ZO);
        tests++;
        if (ZoomLevel !== 5'd0 || pulses !== p0 + 1) begin
            fails++;
            $display("FAIL zoom_min: z=%0d pulses=%0d, expected 0 %0d", ZoomLevel, pulses, p0 + 1);
        end
    endtask

    task automatic test_saturate;
        repeat (3) do_press(RT);
        tests++;
        if (CenterX !== 32'h0) begin
            fails++;
            $display("FAIL x_zero: x=%h, expected 0", CenterX);
        end
        repeat (20) do_press(RT);
        tests++;
        if (CenterX !== 32'h2000_0000) begin
            fails++;
            $display("FAIL x_sat: x=%h, expected 20000000", CenterX);
        end
    endtask

    task automatic test_busy_priority;
        int p0;
        RenderBusy = 1'b1;
        do_press(RT);
        drive(LF);
        model(DN);
        drive(DN);
        p0 = pulses;
        repeat (10) @(negedge Clk);
        tests++;
        if (pulses !== p0) begin
            fails++;
            $display("FAIL busy_hold: pulses=%0d, expected %0d", pulses, p0);
        end
        RenderBusy = 1'b0;
        wait_pulses(p0 + 1, "busy");
        repeat (10) @(negedge Clk);
        tests++;
        if (pulses !== p0 + 1 || CenterX !== 32'h2000_0000) begin
            fails++;
            $display("FAIL pending_clear: pulses=%0d x=%h, expected %0d 20000000", pulses, CenterX, p0 + 1);
        end
    endtask

    task automatic test_mid_reset;
        int p0;
        RenderBusy = 1'b1;
        do_press(LF);
        drive(UP);
        @(posedge Clk);
        #1 Reset = 1'b1;
        mx = INIT_X; my = 0; mz = 0;
        sb.push_back('{mx, my, mz});
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        p0 = pulses + 1;
        wait_pulses(p0, "mid_reset");
        repeat (3) @(negedge Clk);
        RenderBusy = 1'b0;
        repeat (10) @(negedge Clk);
        tests++;
        if (pulses !== p0 || CenterX !== 32'hF800_0000 || CenterY !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset: pulses=%0d x=%h y=%h, expected %0d f8000000 0", pulses, CenterX, CenterY, p0);
        end
    endtask

    initial begin
        test_reset();
        test_right_latency();
        test_simultaneous();
        test_zoom_limits();
        test_saturate();
        test_busy_priority();
        test_mid_reset();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d views never rendered, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mandel_view_ctrl.md
Name: mandel_view_ctrl

Overview:
Consumes the debounced button levels produced by the per-button debouncers and turns them into view updates for the Mandelbrot renderer. It handles pan up/down/left/right and zoom in/out. It holds the current view centre and zoom level, and issues a one-cycle render-start pulse after each view change. It sits between the debouncer bank and the fractal render engine, and uses a busy handshake so that no view change occurs mid-frame.

Parameters:
COORD_W, 32, width of signed fixed-point coordinates (Q4.28, two's complement)
ZOOM_W, 5, width of the zoom level register
MAX_ZOOM, 24, highest allowed zoom level
STEP_BASE, 32'h0200_0000, pan step at zoom 0 (0.125)
COORD_LIMIT, 32'h2000_0000, absolute clamp on each coordinate (2.0)
INIT_X, 32'hF800_0000, reset centre X (-0.5)
INIT_Y, 32'h0000_0000, reset centre Y (0.0)
HOLD_CYCLES, 25000000, hold time before auto-repeat starts (AUTO_REPEAT_EN only)
REPEAT_CYCLES, 5000000, auto-repeat period (AUTO_REPEAT_EN only)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
BtnUp, BtnDown, BtnLeft, BtnRight, BtnZoomIn, BtnZoomOut  in  1 each  debounced button levels (active high)
RenderBusy  in  1  high while the renderer draws a frame
CenterX  out  COORD_W  signed view centre, real axis
CenterY  out  COORD_W  signed view centre, imaginary axis
ZoomLevel  out  ZOOM_W  current zoom level
StartRender  out  1  one-cycle pulse requesting a new frame

Behaviour:
- Reset values:
  - CenterX=INIT_X, CenterY=INIT_Y, ZoomLevel=0, StartRender=0.
  - Button history registers are cleared to 0, the pending mask is cleared, and the state is START.
  - The first frame is therefore requested on the first cycle after Reset deasserts.
- Edge detect: each button has a history flop. An edge is flagged in the cycle where Btn=1 and history=0. Releases are ignored.
- Pending mask (6 bits): edges flagged in any state other than IDLE set their pending bit. The mask clears when IDLE accepts a request. Reset mid-operation clears everything.
- Request priority, highest first: ZoomIn > ZoomOut > Up > Down > Left > Right. One action is taken per update; all other simultaneous or pending requests are discarded.
- FSM states: IDLE, UPDATE, START, WAIT.
  - IDLE: if any edge or pending bit is present, latch the winning action and go to UPDATE. Otherwise stay in IDLE.
  - UPDATE (1 cycle): apply the action; registers take the new value at the end of this cycle. Go to START.
  - START (1 cycle): StartRender=1. Go to WAIT.
  - WAIT: minimum 1 cycle; go to IDLE when RenderBusy=0.
- Latency: a button edge seen in IDLE at cycle n produces updated outputs at cycle n+2 and StartRender high in cycle n+2.
- Step: step = STEP_BASE >>> ZoomLevel (logical shift; the value is positive).
  - Up: CenterY += step. Down: CenterY -= step.
  - Right: CenterX += step. Left: CenterX -= step.
- Arithmetic: sums are computed at COORD_W+1 bits, then saturated to [-COORD_LIMIT, +COORD_LIMIT]. The registers never wrap.
- Zoom: ZoomIn increments ZoomLevel and saturates at MAX_ZOOM. ZoomOut decrements and saturates at 0.
  - A saturated zoom action or a clamped pan still passes through UPDATE/START, so a frame is re-requested.
- Outputs are registered and stable outside UPDATE.

Optional Feature:
Macro: AUTO_REPEAT_EN.
- Defined: a pan button held continuously for HOLD_CYCLES generates a synthetic edge, and then another every REPEAT_CYCLES while it stays held. Synthetic edges follow the same pending and priority rules. A shared counter tracks the highest-priority held pan button; it resets when that button releases or a different button wins. Zoom buttons never repeat.
- Undefined: no counters are instantiated, and only real rising edges produce actions.

Test Plan:
- Reset, then hold RenderBusy=0 -> StartRender pulses once in the first cycle after Reset deasserts; CenterX=32'hF800_0000, CenterY=0, ZoomLevel=0.
- BtnRight edge in IDLE at zoom 0 -> two cycles later CenterX=32'hFA00_0000 and StartRender=1 for exactly one cycle.
- BtnZoomIn and BtnUp rising in the same cycle -> ZoomLevel=1, CenterY unchanged, only one StartRender pulse.
- After 3 ZoomIn presses, press BtnUp -> CenterY increases by 32'h0040_0000. Press ZoomIn 30 times -> ZoomLevel stops at 24. Press ZoomOut at 0 -> stays 0 and StartRender still pulses.
- Press BtnRight 20 times from CenterX=0 at zoom 0 -> CenterX saturates at 32'h2000_0000 with no wrap.
- Hold RenderBusy=1 during WAIT, press BtnLeft then BtnDown -> no update until busy drops; then only Down is applied (higher priority) and the pending mask clears.
